serial_byte_rx: RTL and testbench



---
 rtl/serial_pkg.sv | 20 ++
 rtl/rx_sync_2ff.sv | 30 +++
 rtl/serial_byte_rx.sv | 137 +++++++++++++
 tb/tb_serial_byte_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte receiver: state encoding, frame shape
// and the default bit period.
package serial_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DATA_BITS            = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_DATA  = S_DATA,
        ST_STOP  = S_STOP
    } rx_state_e;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; both stages reset to 1,
// which is the idle level of the serial line.
module rx_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/serial_byte_rx.sv
// Serial byte receiver: 1 start, 8 data bits LSB-first, 1 stop, no parity.
// Delivers each good byte on Dout with a one-cycle Ce_out strobe.
module serial_byte_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] Dout,
    output logic       Ce_out,
    output logic       frame_err,
    output logic       busy
);

    if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 4) begin : g_param_check
        $error("serial_byte_rx: CLKS_PER_BIT must be even and >= 4");
    end

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s;

    rx_sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           dout_q, dout_d;
    logic                 ce_q, ce_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;
    logic                 rx_prev_q, rx_prev_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        ce_d      = 1'b0;
        ferr_d    = 1'b0;
        rx_prev_d = rx_s;

        case (state_q)
            ST_IDLE: begin
                // Only a 1->0 transition starts a frame, so a stuck-low line is ignored.
                if (rx_prev_q && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rx_s) begin
                        dout_d = shreg_q;
                        ce_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered from the next state so busy drops on the same edge the strobe rises.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= '0;
            dout_q    <= 8'h00;
            ce_q      <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            ce_q      <= ce_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    assign Dout      = dout_q;
    assign Ce_out    = ce_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Bench for serial_byte_rx at 4 clocks per bit: directed scenarios plus
// randomized frames scored against frame-level timing expectations.
module tb_serial_byte_rx;

    localparam int C   = 4;
    localparam int H   = C / 2;
    localparam int LAT = 2 + 9 * C + H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] Dout;
    logic       Ce_out;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int overlap_cnt = 0;

    logic [7:0] exp_dout;
    int         ce_cyc_q[$];
    logic [7:0] ce_dat_q[$];
    int         fe_cyc_q[$];
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         exp_fe_q[$];

    serial_byte_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .Dout      (Dout),
        .Ce_out    (Ce_out),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Ce_out) begin
            ce_cyc_q.push_back(cyc);
            ce_dat_q.push_back(Dout);
        end
        if (frame_err) fe_cyc_q.push_back(cyc);
        if (Ce_out && frame_err) overlap_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        ce_cyc_q.delete();
        ce_dat_q.delete();
        fe_cyc_q.delete();
    endtask

    // Drives a whole frame; e0 is the index of the first edge that sees the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e0);
        e0 = cyc + 1;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(C);
        end
        rx = stop_bit;
        tick(C);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_dout = 8'h00;
        n_checks++; if (Dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", Dout); end
        n_checks++; if (Ce_out !== 1'b0) begin n_fail++; $display("FAIL reset_ce: got %b want 0", Ce_out); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            tick(1);
            n_checks++;
            if ({Dout, Ce_out, frame_err, busy} !== 11'd0) begin
                n_fail++;
                $display("FAIL idle_quiet cyc %0d: got dout=%h ce=%b fe=%b busy=%b want all 0",
                         cyc, Dout, Ce_out, frame_err, busy);
            end
        end
    endtask

    task automatic test_single();
        int e0;
        clear_obs();
        send_frame(8'hA5, 1'b1, e0);
        tick(C);
        n_checks++;
        if (ce_cyc_q.size() !== 1) begin
            n_fail++; $display("FAIL single_count: got %0d pulses want 1", ce_cyc_q.size());
        end else begin
            n_checks++; if (ce_cyc_q[0] !== e0 + LAT) begin n_fail++; $display("FAIL single_time: got %0d want %0d", ce_cyc_q[0], e0 + LAT); end
            n_checks++; if (ce_dat_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", ce_dat_q[0]); end
        end
        n_checks++; if (fe_cyc_q.size() !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d want 0", fe_cyc_q.size()); end
        tick(10);
        n_checks++; if (Dout !== 8'hA5) begin n_fail++; $display("FAIL single_hold: got %h want a5", Dout); end
        exp_dout = 8'hA5;
    endtask

    task automatic test_back_to_back();
        int e0, e1;
        clear_obs();
        send_frame(8'h3C, 1'b1, e0);
        send_frame(8'hFF, 1'b1, e1);
        tick(C);
        n_checks++;
        if (ce_cyc_q.size() !== 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d pulses want 2", ce_cyc_q.size());
        end else begin
            n_checks++; if (ce_cyc_q[0] !== e0 + LAT) begin n_fail++; $display("FAIL b2b_time0: got %0d want %0d", ce_cyc_q[0], e0 + LAT); end
            n_checks++; if (ce_cyc_q[1] - ce_cyc_q[0] !== 10 * C) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", ce_cyc_q[1] - ce_cyc_q[0], 10 * C); end
            n_checks++; if (ce_dat_q[0] !== 8'h3C) begin n_fail++; $display("FAIL b2b_data0: got %h want 3c", ce_dat_q[0]); end
            n_checks++; if (ce_dat_q[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_data1: got %h want ff", ce_dat_q[1]); end
        end
        n_checks++; if (Dout !== 8'hFF) begin n_fail++; $display("FAIL b2b_hold: got %h want ff", Dout); end
        exp_dout = 8'hFF;
    endtask

    task automatic test_glitch();
        clear_obs();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(2);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_seen: got busy=%b want 1", busy); end
        tick(H + 1);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got busy=%b want 0", busy); end
        tick(10);
        n_checks++; if (ce_cyc_q.size() + fe_cyc_q.size() !== 0) begin n_fail++; $display("FAIL glitch_strobe: got %0d strobes want 0", ce_cyc_q.size() + fe_cyc_q.size()); end
        n_checks++; if (Dout !== exp_dout) begin n_fail++; $display("FAIL glitch_dout: got %h want %h", Dout, exp_dout); end
    endtask

    task automatic test_frame_err();
        int e0, e1;
        clear_obs();
        send_frame(8'h55, 1'b0, e0);
        rx = 1'b1;
        tick(3);
        n_checks++;
        if (fe_cyc_q.size() !== 1) begin
            n_fail++; $display("FAIL ferr_count: got %0d want 1", fe_cyc_q.size());
        end else begin
            n_checks++; if (fe_cyc_q[0] !== e0 + LAT) begin n_fail++; $display("FAIL ferr_time: got %0d want %0d", fe_cyc_q[0], e0 + LAT); end
        end
        n_checks++; if (ce_cyc_q.size() !== 0) begin n_fail++; $display("FAIL ferr_ce: got %0d pulses want 0", ce_cyc_q.size()); end
        n_checks++; if (Dout !== exp_dout) begin n_fail++; $display("FAIL ferr_dout: got %h want %h", Dout, exp_dout); end
        clear_obs();
        send_frame(8'h12, 1'b1, e1);
        tick(C);
        n_checks++;
        if (ce_cyc_q.size() !== 1) begin
            n_fail++; $display("FAIL ferr_next_count: got %0d want 1", ce_cyc_q.size());
        end else begin
            n_checks++; if (ce_dat_q[0] !== 8'h12) begin n_fail++; $display("FAIL ferr_next_data: got %h want 12", ce_dat_q[0]); end
        end
        exp_dout = 8'h12;
    endtask

    task automatic test_reset_mid_frame();
        int e0;
        logic [7:0] b;
        b = 8'h81;
        clear_obs();
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(C);
        end
        rx = b[4];
        tick(2);
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_dout = 8'h00;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (Dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h want 00", Dout); end
        tick(10 * C);
        n_checks++; if (ce_cyc_q.size() + fe_cyc_q.size() !== 0) begin n_fail++; $display("FAIL midrst_strobe: got %0d want 0", ce_cyc_q.size() + fe_cyc_q.size()); end
        send_frame(8'h81, 1'b1, e0);
        tick(C);
        n_checks++;
        if (ce_cyc_q.size() !== 1) begin
            n_fail++; $display("FAIL midrst_next_count: got %0d want 1", ce_cyc_q.size());
        end else begin
            n_checks++; if (ce_cyc_q[0] !== e0 + LAT) begin n_fail++; $display("FAIL midrst_next_time: got %0d want %0d", ce_cyc_q[0], e0 + LAT); end
            n_checks++; if (ce_dat_q[0] !== 8'h81) begin n_fail++; $display("FAIL midrst_next_data: got %h want 81", ce_dat_q[0]); end
        end
        exp_dout = 8'h81;
    endtask

    task automatic test_random();
        int e0, gap;
        logic [7:0] b;
        logic stop_ok;
        clear_obs();
        exp_q.delete();
        exp_cyc_q.delete();
        exp_fe_q.delete();
        for (int f = 0; f < 12; f++) begin
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(b, stop_ok, e0);
            if (stop_ok) begin
                exp_q.push_back(b);
                exp_cyc_q.push_back(e0 + LAT);
                exp_dout = b;
                gap = $urandom_range(0, 3);
            end else begin
                exp_fe_q.push_back(e0 + LAT);
                gap = $urandom_range(1, 4);
            end
            rx = 1'b1;
            if (gap > 0) tick(gap);
        end
        tick(C + 2);
        n_checks++;
        if (ce_cyc_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_ce_count: got %0d want %0d", ce_cyc_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (ce_dat_q[i] !== exp_q[i] || ce_cyc_q[i] !== exp_cyc_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_byte %0d: got %h at %0d want %h at %0d",
                             i, ce_dat_q[i], ce_cyc_q[i], exp_q[i], exp_cyc_q[i]);
                end
            end
        end
        n_checks++;
        if (fe_cyc_q.size() !== exp_fe_q.size()) begin
            n_fail++; $display("FAIL rand_fe_count: got %0d want %0d", fe_cyc_q.size(), exp_fe_q.size());
        end else begin
            foreach (exp_fe_q[i]) begin
                n_checks++;
                if (fe_cyc_q[i] !== exp_fe_q[i]) begin
                    n_fail++; $display("FAIL rand_fe %0d: got %0d want %0d", i, fe_cyc_q[i], exp_fe_q[i]);
                end
            end
        end
        n_checks++; if (Dout !== exp_dout) begin n_fail++; $display("FAIL rand_dout: got %h want %h", Dout, exp_dout); end
        n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
